// File: rtl/mcu_spi_pkg.sv
// Shared types and constants for the MCU SPI target and the blocks that decode its strobes.
package mcu_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TARGET,
    CMD,
    DATA,
    WAIT_SS
  } state_t;

  localparam logic [7:0] TARGET_SYS = 8'h00;
  localparam logic [7:0] TARGET_HID = 8'h02;
  localparam logic [7:0] TARGET_OSD = 8'h03;
  localparam logic [7:0] TARGET_SDC = 8'h05;

  // Cycles from a strobe until the responder's reply byte is taken into the MISO shifter.
  localparam int REPLY_LOAD_DELAY = 2;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, with single-cycle rise/fall pulses
// derived from the synchronized level.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   level_p;

  always_ff @(posedge clk) begin
    sync_p  <= {sync_p[SYNC_STAGES-2:0], pin};
    level_p <= sync_p[SYNC_STAGES-1];
  end

  assign level = sync_p[SYNC_STAGES-1];
  assign rise  = level & ~level_p;
  assign fall  = ~level & level_p;

endmodule

// File: rtl/mcu_spi_target.sv
// SPI mode-0 target: first byte of a frame selects a responder, second is a command,
// the rest are data; reply bytes from the responder are shifted back on MISO.
module mcu_spi_target
  import mcu_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_io_ss,
  input  logic       spi_io_clk,
  input  logic       spi_io_din,
  output logic       spi_io_dout,
  output logic [7:0] target,
  output logic       frame_active,
  output logic       data_out_strobe,
  output logic       data_out_start,
  output logic [7:0] data_out,
  input  logic [7:0] data_in
);

  logic unused_sck_level, sck_rise, sck_fall;
  logic ss_level, unused_ss_rise, unused_ss_fall;
  logic din_level, unused_din_rise, unused_din_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk   (clk),
    .pin   (spi_io_clk),
    .level (unused_sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
    .clk   (clk),
    .pin   (spi_io_ss),
    .level (ss_level),
    .rise  (unused_ss_rise),
    .fall  (unused_ss_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
    .clk   (clk),
    .pin   (spi_io_din),
    .level (din_level),
    .rise  (unused_din_rise),
    .fall  (unused_din_fall)
  );

  logic sel;
  assign sel = ~ss_level;

  state_t                      state, state_nx;
  logic [2:0]                  bit_cnt;
  logic [7:0]                  rx_shift;
  logic [7:0]                  tx_shift;
  logic [7:0]                  rx_byte;
  logic                        skip_fall;
  logic [REPLY_LOAD_DELAY-1:0] reply_pipe;
  logic                        frame_start, in_frame, done;
  logic                        done_target, done_cmd, done_data;

  assign rx_byte = {rx_shift[6:0], din_level};

  // A frame already in progress when reset releases is skipped until SS rises.
  always_ff @(posedge clk) begin
    if (reset) state <= sel ? WAIT_SS : IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sel) state_nx = TARGET;
      TARGET:  if (!sel) state_nx = IDLE; else if (done) state_nx = CMD;
      CMD:     if (!sel) state_nx = IDLE; else if (done) state_nx = DATA;
      DATA:    if (!sel) state_nx = IDLE;
      WAIT_SS: if (!sel) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Completion is decoded from the current state only, so a byte finishing as SS rises still counts.
  always_comb begin
    frame_start = (state == IDLE) && sel;
    in_frame    = (state == TARGET) || (state == CMD) || (state == DATA);
    done        = in_frame && sck_rise && (bit_cnt == 3'd7);
    done_target = done && (state == TARGET);
    done_cmd    = done && (state == CMD);
    done_data   = done && (state == DATA);
  end

  always_ff @(posedge clk) begin
    if (in_frame && sck_rise) rx_shift <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt         <= 3'd0;
      target          <= 8'h00;
      data_out        <= 8'h00;
      data_out_strobe <= 1'b0;
      data_out_start  <= 1'b0;
      frame_active    <= 1'b0;
      reply_pipe      <= '0;
      skip_fall       <= 1'b0;
    end else begin
      if (frame_start)                bit_cnt <= 3'd0;
      else if (in_frame && sck_rise)  bit_cnt <= bit_cnt + 3'd1;
      if (done_target)                target <= rx_byte;
      if (done_cmd || done_data)      data_out <= rx_byte;
      data_out_strobe <= done_cmd || done_data;
      data_out_start  <= done_cmd;
      if (!sel)                       frame_active <= 1'b0;
      else if (frame_start)           frame_active <= 1'b1;
      reply_pipe <= {reply_pipe[REPLY_LOAD_DELAY-2:0], data_out_strobe};
      // The SCK fall closing a byte must not disturb bit 7 of the freshly loaded reply.
      if (frame_start)                skip_fall <= 1'b0;
      else if (done)                  skip_fall <= 1'b1;
      else if (in_frame && sck_fall)  skip_fall <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                      tx_shift <= 8'h00;
    else if (frame_start || done_target)            tx_shift <= 8'h00;
    else if (reply_pipe[REPLY_LOAD_DELAY-1])        tx_shift <= data_in;
    else if (in_frame && sck_fall && !skip_fall)    tx_shift <= {tx_shift[6:0], 1'b0};
  end

  assign spi_io_dout = tx_shift[7];

endmodule
